// File: rtl/matmul_tile_controller_if.sv
// matmul_tile_controller_if: host/datapath bundle for the tile sequencer.
// Ports (slave = controller view):
//   start, num_rows, stall                       -> into the controller
//   busy, load_weight, weight_addr, enable_mult,
//   data_valid, data_addr, result_valid,
//   result_addr, done                            <- out of the controller
interface matmul_tile_controller_if #(
    parameter int MATRIX_SIZE = 2,
    parameter int MAX_ROWS    = 16
);
    localparam int ROW_W = $clog2(MAX_ROWS + 1);
    localparam int WA_W  = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    logic             start;
    logic [ROW_W-1:0] num_rows;
    logic             stall;
    logic             busy;
    logic             load_weight;
    logic [WA_W-1:0]  weight_addr;
    logic             enable_mult;
    logic             data_valid;
    logic [ROW_W-1:0] data_addr;
    logic             result_valid;
    logic [ROW_W-1:0] result_addr;
    logic             done;
    modport master (
        output start, num_rows, stall,
        input  busy, load_weight, weight_addr, enable_mult, data_valid, data_addr,
               result_valid, result_addr, done
    );
    modport slave (
        input  start, num_rows, stall,
        output busy, load_weight, weight_addr, enable_mult, data_valid, data_addr,
               result_valid, result_addr, done
    );
endinterface

// File: rtl/matmul_tile_controller.sv
// matmul_tile_controller: sequences one weight-stationary tile multiply (load, stream, drain).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    slave side of matmul_tile_controller_if (command in, array/buffer controls out)
module matmul_tile_controller #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int MAX_ROWS    = 16,
    parameter int RESULT_LAT  = 2 * MATRIX_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    matmul_tile_controller_if.slave  bus
);
    localparam int ROW_W = $clog2(MAX_ROWS + 1);
    localparam int WA_W  = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int CMAX  = (MAX_ROWS > RESULT_LAT) ? ((MAX_ROWS > MATRIX_SIZE) ? MAX_ROWS : MATRIX_SIZE)
                                                   : ((RESULT_LAT > MATRIX_SIZE) ? RESULT_LAT : MATRIX_SIZE);
    localparam int CW    = $clog2(CMAX + 1);

    if (DATA_SIZE < 1 || MATRIX_SIZE < 1 || RESULT_LAT < 2) begin : g_bad_param
        $error("matmul_tile_controller: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [ROW_W-1:0]            rows_q, rows_d;
    logic [RESULT_LAT-1:0]       pv_q, pv_d;
    logic [RESULT_LAT*ROW_W-1:0] pa_q, pa_d;
    logic                        en, dv;
    logic [ROW_W-1:0]            da;

    // Stall gates the enables in its own cycle; addresses keep pointing at the held row.
    assign en = (state_q == STREAM || state_q == DRAIN) && !bus.stall;
    assign dv = state_q == STREAM && !bus.stall;
    assign da = (state_q == STREAM) ? ROW_W'(cnt_q) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rows_q  <= '0;
            pv_q    <= '0;
            pa_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rows_q  <= rows_d;
            pv_q    <= pv_d;
            pa_q    <= pa_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rows_d  = rows_q;
        pv_d    = en ? {pv_q[RESULT_LAT-2:0], dv} : pv_q;
        pa_d    = en ? {pa_q[(RESULT_LAT-1)*ROW_W-1:0], da} : pa_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rows_d  = (bus.num_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : bus.num_rows;
                    cnt_d   = '0;
                    state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                if (!bus.stall) begin
                    cnt_d = (cnt_q == CW'(MATRIX_SIZE - 1)) ? '0 : cnt_q + CW'(1);
                    if (cnt_q == CW'(MATRIX_SIZE - 1))
                        state_d = (rows_q == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (!bus.stall) begin
                    cnt_d = (cnt_q == CW'(rows_q) - CW'(1)) ? '0 : cnt_q + CW'(1);
                    if (cnt_q == CW'(rows_q) - CW'(1))
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.stall) begin
                    cnt_d = (cnt_q == CW'(RESULT_LAT - 1)) ? '0 : cnt_q + CW'(1);
                    if (cnt_q == CW'(RESULT_LAT - 1))
                        state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy         = state_q != IDLE;
    assign bus.load_weight  = state_q == LOAD_W && !bus.stall;
    assign bus.weight_addr  = (state_q == LOAD_W) ? WA_W'(MATRIX_SIZE - 1) - WA_W'(cnt_q) : '0;
    assign bus.enable_mult  = en;
    assign bus.data_valid   = dv;
    assign bus.data_addr    = da;
    assign bus.result_valid = pv_q[RESULT_LAT-1] && en;
    assign bus.result_addr  = pv_q[RESULT_LAT-1] ? pa_q[RESULT_LAT*ROW_W-1 -: ROW_W] : '0;
    assign bus.done         = state_q == DONE;
endmodule

// File: tb/tb_matmul_tile_controller.sv
// tb_matmul_tile_controller: directed checks of the tile sequencer (N=2, LAT=4, MAX_ROWS=16).
module tb_matmul_tile_controller;
    localparam int N     = 2;
    localparam int LAT   = 2 * N;
    localparam int MAXR  = 16;
    localparam int ROW_W = $clog2(MAXR + 1);

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   nd, nv;

    always #5 clk = ~clk;

    matmul_tile_controller_if #(.MATRIX_SIZE(N), .MAX_ROWS(MAXR)) bus ();

    matmul_tile_controller #(
        .MATRIX_SIZE(N), .DATA_SIZE(32), .MAX_ROWS(MAXR), .RESULT_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input int t, input int lw, input int wa, input int en,
                               input int dv, input int da, input int rv, input int ra, input int dn,
                               input int bz);
        string p;
        p = $sformatf("%s@%0d", tag, t);
        chk({p, " load_weight"},  32'(bus.load_weight),  lw);
        chk({p, " weight_addr"},  32'(bus.weight_addr),  wa);
        chk({p, " enable_mult"},  32'(bus.enable_mult),  en);
        chk({p, " data_valid"},   32'(bus.data_valid),   dv);
        chk({p, " data_addr"},    32'(bus.data_addr),    da);
        chk({p, " result_valid"}, 32'(bus.result_valid), rv);
        chk({p, " result_addr"},  32'(bus.result_addr),  ra);
        chk({p, " done"},         32'(bus.done),         dn);
        chk({p, " busy"},         32'(bus.busy),         bz);
    endtask

    // Unstalled burst of r rows started at t=0; t outside the burst expects all-zero outputs.
    task automatic exp_burst(input string tag, input int t, input int r);
        int dl, l, d, v, e;
        dl = (r == 0) ? 3 : 3 + r + LAT;
        l  = int'(t >= 1 && t <= 2);
        d  = int'(t >= 3 && t <= 2 + r);
        v  = int'(r > 0 && t >= 3 + LAT && t <= 2 + r + LAT);
        e  = int'(r > 0 && t >= 3 && t < dl);
        check_cycle(tag, t, l, (l != 0) ? N - t : 0, e, d, (d != 0) ? t - 3 : 0, v,
                    (v != 0) ? t - 3 - LAT : 0, int'(t == dl), int'(t >= 1 && t <= dl));
    endtask

    task automatic drive(input logic s, input int nr, input logic st, input logic rs);
        bus.start    = s;
        bus.num_rows = ROW_W'(nr);
        bus.stall    = st;
        reset        = rs;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.num_rows = ROW_W'(3);
        bus.stall    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_cycle("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();

        for (int t = 0; t <= 11; t++) begin
            drive(t == 0, 3, 1'b0, 1'b0);
            exp_burst("s1", t, 3);
            adv();
        end

        for (int t = 0; t <= 13; t++) begin
            int en, dv, da, rv;
            drive(t == 0, 3, t == 4 || t == 8 || t == 12, 1'b0);
            en = int'(t >= 3 && t <= 11 && t != 4 && t != 8);
            dv = int'(t == 3 || t == 5 || t == 6);
            da = (t == 4 || t == 5) ? 1 : (t == 6) ? 2 : 0;
            rv = int'(t >= 9 && t <= 11);
            check_cycle("s2", t, int'(t == 1 || t == 2), int'(t == 1), en, dv, da, rv,
                        (rv != 0) ? t - 9 : 0, int'(t == 12), int'(t >= 1 && t <= 12));
            adv();
        end

        for (int t = 0; t <= 4; t++) begin
            drive(t == 0, 0, 1'b0, 1'b0);
            exp_burst("s3", t, 0);
            adv();
        end

        nd = 0;
        nv = 0;
        for (int t = 0; t <= 24; t++) begin
            drive(t == 0, 20, 1'b0, 1'b0);
            exp_burst("s4", t, 16);
            nd += int'(bus.data_valid);
            nv += int'(bus.result_valid);
            adv();
        end
        chk("s4 data_valid count", nd, 16);
        chk("s4 result_valid count", nv, 16);

        for (int t = 0; t <= 21; t++) begin
            drive(t == 0 || t == 4 || t == 10 || t == 11, (t == 0) ? 3 : (t == 11) ? 2 : 7, 1'b0, 1'b0);
            if (t <= 11) exp_burst("s5", t, 3);
            else exp_burst("s5b", t - 11, 2);
            adv();
        end

        for (int t = 0; t <= 8; t++) begin
            drive(t == 0, 3, 1'b0, t == 6);
            exp_burst("s6", (t <= 6) ? t : -1, 3);
            adv();
        end
        for (int t = 0; t <= 11; t++) begin
            drive(t == 0, 3, 1'b0, 1'b0);
            exp_burst("s6r", t, 3);
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
